// File: rtl/monopix_readout.sv
// MONOPIX-style pixel matrix: per-pixel hit capture with Gray BCID timestamps,
// token/freeze handshake and a 27-bit serial hit word shifted out MSB first.
module monopix_readout #(
    parameter int N_COL = 8,
    parameter int N_ROW = 16
) (
    input  logic                   clk_bx,
    input  logic                   rst_n,
    input  logic                   reset_bcid,
    input  logic [N_COL*N_ROW-1:0] ana_hit,
    input  logic [N_COL*N_ROW-1:0] en_pix,
    input  logic [N_COL*N_ROW-1:0] inj_en,
    input  logic                   pulse,
    input  logic                   freeze,
    input  logic                   read,
    output logic                   token,
    output logic                   out
);
    localparam int N_PIX  = N_COL * N_ROW;
    localparam int WORD_W = 27;

    typedef enum logic [1:0] {
        PIX_IDLE,
        PIX_HIT,
        PIX_PEND,
        PIX_READY
    } pix_state_t;

    logic [5:0]        bcid_bin;
    logic [5:0]        bcid_gray;
    logic [N_PIX-1:0]  hit_raw;
    logic [N_PIX-1:0]  sync1;
    logic [N_PIX-1:0]  sync2;
    logic [N_PIX-1:0]  hit_dly;
    pix_state_t        pix_state [N_PIX];
    logic [5:0]        le_ts [N_PIX];
    logic [5:0]        te_ts [N_PIX];
    logic [N_PIX-1:0]  ready_vec;
    logic [N_PIX-1:0]  cand;
    logic [N_PIX-1:0]  sel_onehot;
    logic              sel_valid;
    logic [WORD_W-1:0] sel_word;
    logic              sel_take;
    logic              read_q;
    logic              sel_pending;
    logic              load_wait;
    logic [4:0]        shift_cnt;
    logic [WORD_W-1:0] shreg;

    assign bcid_gray = bcid_bin ^ (bcid_bin >> 1);
    assign hit_raw   = (ana_hit | ({N_PIX{pulse}} & inj_en)) & en_pix;
    assign sel_take  = sel_pending & sel_valid;

    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            bcid_bin <= '0;
        end else if (reset_bcid) begin
            bcid_bin <= '0;
        end else begin
            bcid_bin <= bcid_bin + 6'd1;
        end
    end

    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            hit_dly <= '0;
        end else begin
            sync1   <= hit_raw;
            sync2   <= sync1;
            hit_dly <= sync2;
        end
    end

    // A pending pixel that is promoted on the selection edge is already a candidate.
    always_comb begin
        ready_vec = '0;
        cand      = '0;
        for (int i = 0; i < N_PIX; i++) begin
            ready_vec[i] = (pix_state[i] == PIX_READY);
            cand[i]      = (pix_state[i] == PIX_READY) ||
                           ((pix_state[i] == PIX_PEND) && !freeze);
        end
    end

    // Column-major priority: lowest column first, then lowest row.
    always_comb begin
        sel_valid  = 1'b0;
        sel_onehot = '0;
        sel_word   = '0;
        for (int c = 0; c < N_COL; c++) begin
            for (int r = 0; r < N_ROW; r++) begin
                if (!sel_valid && cand[r*N_COL + c]) begin
                    sel_valid               = 1'b1;
                    sel_onehot[r*N_COL + c] = 1'b1;
                    sel_word = {6'(c), te_ts[r*N_COL + c], le_ts[r*N_COL + c], 9'(r)};
                end
            end
        end
    end

    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PIX; i++) begin
                pix_state[i] <= PIX_IDLE;
                le_ts[i]     <= '0;
                te_ts[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N_PIX; i++) begin
                if (sel_take && sel_onehot[i]) begin
                    pix_state[i] <= PIX_IDLE;
                end else begin
                    case (pix_state[i])
                        PIX_IDLE: begin
                            if (sync2[i] && !hit_dly[i]) begin
                                le_ts[i]     <= bcid_gray;
                                pix_state[i] <= PIX_HIT;
                            end
                        end
                        PIX_HIT: begin
                            if (!sync2[i] && hit_dly[i]) begin
                                te_ts[i]     <= bcid_gray;
                                pix_state[i] <= PIX_PEND;
                            end
                        end
                        PIX_PEND: begin
                            if (!freeze) begin
                                pix_state[i] <= PIX_READY;
                            end
                        end
                        default: begin
                            pix_state[i] <= pix_state[i];
                        end
                    endcase
                end
            end
        end
    end

    // Word is latched one edge after the READ rise, held one edge, then shifted.
    always_ff @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n) begin
            read_q      <= 1'b0;
            sel_pending <= 1'b0;
            load_wait   <= 1'b0;
            shift_cnt   <= '0;
            shreg       <= '0;
            token       <= 1'b0;
            out         <= 1'b0;
        end else begin
            read_q      <= read;
            sel_pending <= read & ~read_q;
            token       <= |ready_vec;
            if (sel_pending) begin
                shreg     <= sel_valid ? sel_word : '0;
                load_wait <= 1'b1;
                shift_cnt <= '0;
                out       <= 1'b0;
            end else if (load_wait) begin
                load_wait <= 1'b0;
                shift_cnt <= 5'(WORD_W);
                out       <= 1'b0;
            end else if (shift_cnt != '0) begin
                out       <= shreg[WORD_W-1];
                shreg     <= {shreg[WORD_W-2:0], 1'b0};
                shift_cnt <= shift_cnt - 5'd1;
            end else begin
                out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_monopix_readout.sv
// Directed bench for monopix_readout: table of single-pixel hits plus
// hand sequences for priority, injection, freeze, abort and reset cases.
module tb_monopix_readout;
    localparam int N_COL = 8;
    localparam int N_ROW = 16;
    localparam int N_PIX = N_COL * N_ROW;
    localparam int N_VEC = 8;

    logic             clk_bx = 1'b0;
    logic             rst_n;
    logic             reset_bcid;
    logic [N_PIX-1:0] ana_hit;
    logic [N_PIX-1:0] en_pix;
    logic [N_PIX-1:0] inj_en;
    logic             pulse;
    logic             freeze;
    logic             read;
    logic             token;
    logic             out;
    logic [5:0]       tb_bcid;
    int               assert_count = 0;
    int               fail_count = 0;

    typedef struct {
        int col;
        int row;
        int len;
        bit inj;
        bit en;
        bit exp_valid;
        int exp_dt;
    } vec_t;

    vec_t vecs [N_VEC];

    monopix_readout #(.N_COL(N_COL), .N_ROW(N_ROW)) dut (
        .clk_bx    (clk_bx),
        .rst_n     (rst_n),
        .reset_bcid(reset_bcid),
        .ana_hit   (ana_hit),
        .en_pix    (en_pix),
        .inj_en    (inj_en),
        .pulse     (pulse),
        .freeze    (freeze),
        .read      (read),
        .token     (token),
        .out       (out)
    );

    always #5 clk_bx = ~clk_bx;

    // Reference bunch-crossing counter used to predict timestamps.
    always @(posedge clk_bx or negedge rst_n) begin
        if (!rst_n)          tb_bcid <= '0;
        else if (reset_bcid) tb_bcid <= '0;
        else                 tb_bcid <= tb_bcid + 6'd1;
    end

    function automatic logic [5:0] toGray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] fromGray(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int deltaT(input logic [26:0] w);
        logic [5:0] d;
        d = fromGray(w[20:15]) - fromGray(w[14:9]);
        return int'(d);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [26:0] w,
                             input int col, input int row, input int dt);
        checkOutput({tag, "_col"}, 32'(w[26:21]), 32'(col));
        checkOutput({tag, "_row"}, 32'(w[8:0]), 32'(row));
        checkOutput({tag, "_dt"}, 32'(deltaT(w)), 32'(dt));
    endtask

    // Drives one hit for len cycles from the current falling edge; returns the
    // expected Gray LE, i.e. the BCID in force at the capturing edge.
    task automatic applyStimulus(input int idx, input int len, input bit inj,
                                 output logic [5:0] le_exp);
        le_exp = '0;
        if (inj) pulse = 1'b1;
        else     ana_hit[idx] = 1'b1;
        for (int c = 1; c <= len + 2; c++) begin
            @(negedge clk_bx);
            if (c == 2) le_exp = toGray(tb_bcid);
            if (c == len) begin
                pulse        = 1'b0;
                ana_hit[idx] = 1'b0;
            end
        end
    endtask

    // Pulses (or holds) READ and deserializes OUT after edges E+3 .. E+29.
    task automatic readWord(input int hold_extra, output logic [26:0] w);
        int stray;
        w     = '0;
        stray = 0;
        read  = 1'b1;
        @(negedge clk_bx);
        if (hold_extra == 0) read = 1'b0;
        repeat (2) @(negedge clk_bx);
        for (int k = 26; k >= 0; k--) begin
            @(negedge clk_bx);
            w[k] = out;
        end
        if (hold_extra > 0) begin
            for (int c = 0; c < hold_extra; c++) begin
                @(negedge clk_bx);
                if (out !== 1'b0) stray++;
            end
            checkOutput("out_idle_while_read_held", 32'(stray), 32'd0);
            read = 1'b0;
            @(negedge clk_bx);
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: actual no finish, required finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        logic [26:0] w;
        logic [5:0]  le_exp;
        logic [5:0]  te_exp;
        int          idx;
        int          idx_b;
        int          stray;

        vecs[0] = '{7,  2,  9, 1'b0, 1'b1, 1'b1,  9};
        vecs[1] = '{7, 15,  1, 1'b0, 1'b1, 1'b1,  1};
        vecs[2] = '{3,  9, 70, 1'b0, 1'b1, 1'b1,  6};
        vecs[3] = '{1,  5,  4, 1'b1, 1'b1, 1'b1,  4};
        vecs[4] = '{2,  4,  4, 1'b1, 1'b0, 1'b0,  0};
        vecs[5] = '{5, 11, 63, 1'b0, 1'b1, 1'b1, 63};
        vecs[6] = '{0,  0,  8, 1'b0, 1'b1, 1'b1,  8};
        vecs[7] = '{6,  7,  2, 1'b0, 1'b0, 1'b0,  0};

        rst_n      = 1'b0;
        reset_bcid = 1'b1;
        ana_hit    = '0;
        en_pix     = '1;
        inj_en     = '0;
        pulse      = 1'b0;
        freeze     = 1'b0;
        read       = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk_bx);
        checkOutput("reset_token", 32'(token), 32'd0);
        checkOutput("reset_out", 32'(out), 32'd0);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_bx);
            if (token !== 1'b0 || out !== 1'b0) stray++;
        end
        checkOutput("idle_token_out_quiet", 32'(stray), 32'd0);

        // Single hit right after BCID release: LE at BCID 2, TE at BCID 10
        reset_bcid = 1'b0;
        applyStimulus(0, 8, 1'b0, le_exp);
        repeat (2) @(negedge clk_bx);
        checkOutput("single_token_low", 32'(token), 32'd0);
        @(negedge clk_bx);
        checkOutput("single_token_rise", 32'(token), 32'd1);
        readWord(0, w);
        checkWord("single", w, 0, 0, 8);
        checkOutput("single_le_gray", 32'(w[14:9]), 32'd3);
        checkOutput("single_te_gray", 32'(w[20:15]), 32'd15);
        @(negedge clk_bx);
        checkOutput("single_token_after", 32'(token), 32'd0);

        // Table of isolated single-pixel hits
        for (int v = 0; v < N_VEC; v++) begin
            idx         = vecs[v].row * N_COL + vecs[v].col;
            en_pix[idx] = vecs[v].en;
            inj_en[idx] = vecs[v].inj;
            @(negedge clk_bx);
            applyStimulus(idx, vecs[v].len, vecs[v].inj, le_exp);
            repeat (2) @(negedge clk_bx);
            checkOutput($sformatf("vec%0d_token_low", v), 32'(token), 32'd0);
            @(negedge clk_bx);
            checkOutput($sformatf("vec%0d_token", v), 32'(token), 32'(vecs[v].exp_valid));
            readWord(0, w);
            if (vecs[v].exp_valid) begin
                checkWord($sformatf("vec%0d", v), w, vecs[v].col, vecs[v].row, vecs[v].exp_dt);
                checkOutput($sformatf("vec%0d_le", v), 32'(w[14:9]), 32'(le_exp));
            end else begin
                checkOutput($sformatf("vec%0d_zero_word", v), 32'(w), 32'd0);
            end
            @(negedge clk_bx);
            checkOutput($sformatf("vec%0d_out_tail", v), 32'(out), 32'd0);
            checkOutput($sformatf("vec%0d_token_after", v), 32'(token), 32'd0);
            en_pix[idx] = 1'b1;
            inj_en[idx] = 1'b0;
        end

        // Two overlapping hits; READ held high must still give one word
        idx   = 0;
        idx_b = 2 * N_COL + (N_COL - 1);
        ana_hit[idx] = 1'b1;
        @(negedge clk_bx);
        ana_hit[idx_b] = 1'b1;
        repeat (7) @(negedge clk_bx);
        ana_hit[idx] = 1'b0;
        repeat (2) @(negedge clk_bx);
        ana_hit[idx_b] = 1'b0;
        repeat (8) @(negedge clk_bx);
        checkOutput("prio_token", 32'(token), 32'd1);
        readWord(10, w);
        checkWord("prio_first", w, 0, 0, 8);
        checkOutput("prio_token_still", 32'(token), 32'd1);
        readWord(0, w);
        checkWord("prio_second", w, N_COL - 1, 2, 9);
        @(negedge clk_bx);
        checkOutput("prio_token_after", 32'(token), 32'd0);

        // Injection: two enabled pixels, one disabled
        inj_en[0 * N_COL + 1] = 1'b1;
        inj_en[5 * N_COL + 1] = 1'b1;
        inj_en[4 * N_COL + 2] = 1'b1;
        en_pix[4 * N_COL + 2] = 1'b0;
        @(negedge clk_bx);
        pulse = 1'b1;
        repeat (4) @(negedge clk_bx);
        pulse = 1'b0;
        repeat (8) @(negedge clk_bx);
        readWord(0, w);
        checkWord("inj_first", w, 1, 0, 4);
        readWord(0, w);
        checkWord("inj_second", w, 1, 5, 4);
        @(negedge clk_bx);
        checkOutput("inj_token_after", 32'(token), 32'd0);
        inj_en = '0;
        en_pix = '1;

        // Freeze holds a completed hit in PEND; readout still works under freeze
        freeze = 1'b1;
        idx    = 3 * N_COL + 4;
        @(negedge clk_bx);
        applyStimulus(idx, 5, 1'b0, le_exp);
        repeat (10) @(negedge clk_bx);
        checkOutput("freeze_token_low", 32'(token), 32'd0);
        readWord(0, w);
        checkOutput("freeze_empty_word", 32'(w), 32'd0);
        checkOutput("freeze_token_low2", 32'(token), 32'd0);
        freeze = 1'b0;
        repeat (2) @(negedge clk_bx);
        checkOutput("freeze_token_rise", 32'(token), 32'd1);
        freeze = 1'b1;
        readWord(0, w);
        checkWord("freeze_word", w, 4, 3, 5);
        checkOutput("freeze_le", 32'(w[14:9]), 32'(le_exp));
        @(negedge clk_bx);
        checkOutput("freeze_token_after", 32'(token), 32'd0);
        freeze = 1'b0;

        // New READ edge mid-shift aborts and reads the next pixel
        ana_hit[3 * N_COL + 0] = 1'b1;
        ana_hit[1 * N_COL + 4] = 1'b1;
        repeat (3) @(negedge clk_bx);
        ana_hit = '0;
        repeat (8) @(negedge clk_bx);
        read = 1'b1;
        @(negedge clk_bx);
        read = 1'b0;
        repeat (12) @(negedge clk_bx);
        readWord(0, w);
        checkWord("abort_word", w, 4, 1, 3);
        @(negedge clk_bx);
        checkOutput("abort_token_after", 32'(token), 32'd0);

        // RESET_BCID on the leading-edge capture edge keeps the pre-clear value
        idx = 6 * N_COL + 2;
        ana_hit[idx] = 1'b1;
        repeat (2) @(negedge clk_bx);
        le_exp     = toGray(tb_bcid);
        reset_bcid = 1'b1;
        @(negedge clk_bx);
        reset_bcid = 1'b0;
        repeat (4) @(negedge clk_bx);
        ana_hit[idx] = 1'b0;
        repeat (2) @(negedge clk_bx);
        te_exp = toGray(tb_bcid);
        repeat (6) @(negedge clk_bx);
        readWord(0, w);
        checkOutput("rbcid_le", 32'(w[14:9]), 32'(le_exp));
        checkOutput("rbcid_te", 32'(w[20:15]), 32'(te_exp));
        checkOutput("rbcid_row", 32'(w[8:0]), 32'd6);

        // Asynchronous reset in the middle of shifting
        ana_hit[0 * N_COL + 7] = 1'b1;
        ana_hit[4 * N_COL + 7] = 1'b1;
        repeat (3) @(negedge clk_bx);
        ana_hit = '0;
        repeat (8) @(negedge clk_bx);
        read = 1'b1;
        @(negedge clk_bx);
        read = 1'b0;
        repeat (6) @(negedge clk_bx);
        checkOutput("midrst_out_bit23", 32'(out), 32'd1);
        checkOutput("midrst_token_pre", 32'(token), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out", 32'(out), 32'd0);
        checkOutput("midrst_token", 32'(token), 32'd0);
        @(negedge clk_bx);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_bx);
        checkOutput("midrst_token_later", 32'(token), 32'd0);
        readWord(0, w);
        checkOutput("midrst_empty_word", 32'(w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
